// File: rtl/tc_5_forward_converter_pkg.sv
// Shared definitions for the mod-5 thermometer-coded (TC5) RNS channel:
// residue code constants and the forward-converter FSM state encoding.
package tc_5_forward_converter_pkg;

   typedef logic [4:1] tc5_t;

   localparam tc5_t TC5_0 = 4'b0000;
   localparam tc5_t TC5_1 = 4'b0001;
   localparam tc5_t TC5_2 = 4'b0011;
   localparam tc5_t TC5_3 = 4'b0111;
   localparam tc5_t TC5_4 = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CONV = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/tc_5_forward_converter_if.sv
// Operand-in / residue-out valid-ready bundle of the forward converter.
// The master side drives operands and accepts results; the slave side is the converter.
interface tc_5_forward_converter_if
   import tc_5_forward_converter_pkg::*;
#(
   parameter int DATA_W = 16
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   tc5_t              out_residue;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_residue
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_residue
   );
endinterface

// File: rtl/tc_5_double_add.sv
// One serial reduction step in TC5: r_out = (2*r_in + b) mod 5.
// Illegal input codes collapse to zero so only valid TC5 codes ever leave.
module tc_5_double_add
   import tc_5_forward_converter_pkg::*;
(
   input  tc5_t r_in,
   input  logic b,
   output tc5_t r_out
);
   tc5_t dbl;

   always_comb begin
      case (r_in)
         TC5_1:   dbl = TC5_2;
         TC5_2:   dbl = TC5_4;
         TC5_3:   dbl = TC5_1;
         TC5_4:   dbl = TC5_3;
         default: dbl = TC5_0;
      endcase
      r_out = dbl;
      // Adding one to a thermometer code is a shift-in of a 1, except 4+1 wraps to 0
      if (b) begin
         r_out = (dbl == TC5_4) ? TC5_0 : {dbl[3:1], 1'b1};
      end
   end
endmodule

// File: rtl/tc_5_forward_converter.sv
// Serial binary-to-TC5 forward converter: consumes the captured operand MSB-first,
// one bit per cycle, and presents the mod-5 residue with a valid/ready handshake.
module tc_5_forward_converter
   import tc_5_forward_converter_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   tc_5_forward_converter_if.slave bus,
   output logic                   busy
);
   localparam int CNT_W = $clog2(DATA_W + 1);

   state_t            state, state_nx;
   logic [DATA_W-1:0] shift;
   logic [CNT_W-1:0]  cnt;
   tc5_t              residue;
   tc5_t              residue_step;
   logic              accept;

   tc_5_double_add u_step (
      .r_in  (residue),
      .b     (shift[DATA_W-1]),
      .r_out (residue_step)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         shift   <= '0;
         cnt     <= '0;
         residue <= TC5_0;
      end else begin
         state <= state_nx;
         if (accept) begin
            shift   <= bus.in_data;
            residue <= TC5_0;
            cnt     <= CNT_W'(DATA_W);
         end else if (state == ST_CONV) begin
            shift   <= shift << 1;
            residue <= residue_step;
            cnt     <= cnt - 1'b1;
         end
      end
   end

   always_comb begin
      state_nx      = state;
      accept        = 1'b0;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      busy          = 1'b1;
      case (state)
         ST_IDLE: begin
            bus.in_ready = 1'b1;
            busy         = 1'b0;
            if (bus.in_valid) begin
               accept   = 1'b1;
               state_nx = ST_CONV;
            end
         end
         ST_CONV: begin
            if (cnt == CNT_W'(1)) state_nx = ST_DONE;
         end
         ST_DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_nx = ST_IDLE;
         end
         default: begin
            busy     = 1'b0;
            state_nx = ST_IDLE;
         end
      endcase
   end

   // Residue register stays visible after the handshake until the next accept
   assign bus.out_residue = residue;

endmodule

// File: tb/tb_tc_5_forward_converter.sv
// Bench for the TC5 forward converter: directed vectors from the residue table,
// backpressure, reset abort, input churn during conversion, DATA_W=1 and random sweeps.
module tb_tc_5_forward_converter;
   logic clk;
   logic rst_n;
   logic busy16, busy1;
   int   total;
   int   bad;

   tc_5_forward_converter_if #(.DATA_W(16)) b16 ();
   tc_5_forward_converter_if #(.DATA_W(1))  b1 ();

   tc_5_forward_converter #(.DATA_W(16)) dut16 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b16),
      .busy  (busy16)
   );

   tc_5_forward_converter #(.DATA_W(1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b1),
      .busy  (busy1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: thermometer code of (v mod 5), i.e. (v mod 5) ones from the bottom
   function automatic logic [4:1] tc5_of(input longint unsigned v);
      int r;
      r = int'(v % 5);
      return 4'((1 << r) - 1);
   endfunction

   // Drives one operand into the 16-bit DUT and completes the output handshake after 'hold' cycles
   task automatic run16(input logic [15:0] d, input int hold, output logic [4:1] res, output bit ok);
      int n;
      @(negedge clk);
      b16.in_valid = 1'b1;
      b16.in_data  = d;
      @(negedge clk);
      b16.in_valid = 1'b0;
      n = 0;
      while (n < 40 && !b16.out_valid) begin
         @(negedge clk);
         n++;
      end
      ok  = b16.out_valid;
      res = b16.out_residue;
      repeat (hold) @(negedge clk);
      b16.out_ready = 1'b1;
      @(negedge clk);
      b16.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      total++;
      if (b16.in_ready !== 1'b1 || b16.out_valid !== 1'b0 || b16.out_residue !== 4'b0000 || busy16 !== 1'b0) begin
         bad++;
         $display("FAIL reset_in_reset: rdy=%b vld=%b res=%b busy=%b want 1 0 0000 0",
                  b16.in_ready, b16.out_valid, b16.out_residue, busy16);
      end
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (b16.in_ready !== 1'b1 || b16.out_valid !== 1'b0 || b1.in_ready !== 1'b1 || b1.out_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_release: rdy16=%b vld16=%b rdy1=%b vld1=%b want 1 0 1 0",
                  b16.in_ready, b16.out_valid, b1.in_ready, b1.out_valid);
      end
   endtask

   task automatic test_latency();
      bit exp_vld;
      b16.in_valid = 1'b1;
      b16.in_data  = 16'h0000;
      @(negedge clk);
      b16.in_valid = 1'b0;
      for (int e = 1; e <= 16; e++) begin
         @(negedge clk);
         exp_vld = (e == 16);
         total++;
         if (b16.out_valid !== exp_vld || b16.in_ready !== 1'b0 || busy16 !== 1'b1) begin
            bad++;
            $display("FAIL latency_edge%0d: vld=%b rdy=%b busy=%b want vld=%b rdy=0 busy=1",
                     e, b16.out_valid, b16.in_ready, busy16, exp_vld);
         end
      end
      total++;
      if (b16.out_residue !== 4'b0000) begin
         bad++;
         $display("FAIL zero_residue: got %b want 0000", b16.out_residue);
      end
      b16.out_ready = 1'b1;
      @(negedge clk);
      b16.out_ready = 1'b0;
      total++;
      if (b16.out_valid !== 1'b0 || b16.in_ready !== 1'b1) begin
         bad++;
         $display("FAIL latency_return_idle: vld=%b rdy=%b want 0 1", b16.out_valid, b16.in_ready);
      end
   endtask

   task automatic test_vectors();
      logic [15:0] vin  [4] = '{16'h0007, 16'h0013, 16'h1235, 16'hFFFF};
      logic [4:1]  vexp [4] = '{4'b0011, 4'b1111, 4'b0001, 4'b0000};
      logic [4:1]  res;
      bit ok;
      for (int i = 0; i < 4; i++) begin
         run16(vin[i], 0, res, ok);
         total++;
         if (!ok || res !== vexp[i]) begin
            bad++;
            $display("FAIL vector_%h: ok=%b got %b want %b", vin[i], ok, res, vexp[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      int n;
      @(negedge clk);
      b16.in_valid = 1'b1;
      b16.in_data  = 16'h1235;
      @(negedge clk);
      b16.in_valid = 1'b0;
      n = 0;
      while (n < 40 && !b16.out_valid) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (b16.out_valid !== 1'b1) begin
         bad++;
         $display("FAIL bp_timeout: out_valid never rose within 40 cycles");
      end
      b16.in_valid = 1'b1;
      b16.in_data  = 16'h0002;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         total++;
         if (b16.out_valid !== 1'b1 || b16.out_residue !== 4'b0001 || b16.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold%0d: vld=%b res=%b rdy=%b want 1 0001 0",
                     c, b16.out_valid, b16.out_residue, b16.in_ready);
         end
      end
      b16.in_valid  = 1'b0;
      b16.out_ready = 1'b1;
      @(negedge clk);
      b16.out_ready = 1'b0;
      total++;
      if (b16.out_valid !== 1'b0 || b16.in_ready !== 1'b1 || busy16 !== 1'b0 || b16.out_residue !== 4'b0001) begin
         bad++;
         $display("FAIL bp_release: vld=%b rdy=%b busy=%b res=%b want 0 1 0 0001",
                  b16.out_valid, b16.in_ready, busy16, b16.out_residue);
      end
   endtask

   task automatic test_reset_mid();
      logic [4:1] res;
      bit ok;
      bit seen;
      @(negedge clk);
      b16.in_valid = 1'b1;
      b16.in_data  = 16'h0013;
      @(negedge clk);
      b16.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      total++;
      if (b16.out_valid !== 1'b0 || b16.in_ready !== 1'b1 || b16.out_residue !== 4'b0000) begin
         bad++;
         $display("FAIL midreset_immediate: vld=%b rdy=%b res=%b want 0 1 0000",
                  b16.out_valid, b16.in_ready, b16.out_residue);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (b16.out_valid) seen = 1;
      end
      total++;
      if (seen) begin
         bad++;
         $display("FAIL midreset_no_result: got out_valid after abort, want none");
      end
      run16(16'h0009, 0, res, ok);
      total++;
      if (!ok || res !== 4'b1111) begin
         bad++;
         $display("FAIL midreset_next_op: ok=%b got %b want 1111", ok, res);
      end
   endtask

   task automatic test_input_churn();
      logic [15:0] d;
      int n;
      for (int k = 0; k < 4; k++) begin
         d = 16'($urandom);
         @(negedge clk);
         b16.in_valid = 1'b1;
         b16.in_data  = d;
         @(negedge clk);
         n = 0;
         while (n < 40 && !b16.out_valid) begin
            b16.in_valid = 1'($urandom);
            b16.in_data  = 16'($urandom);
            @(negedge clk);
            n++;
         end
         b16.in_valid = 1'b0;
         total++;
         if (b16.out_valid !== 1'b1 || b16.out_residue !== tc5_of(longint'(d))) begin
            bad++;
            $display("FAIL churn_%h: vld=%b got %b want %b", d, b16.out_valid, b16.out_residue, tc5_of(longint'(d)));
         end
         b16.out_ready = 1'b1;
         @(negedge clk);
         b16.out_ready = 1'b0;
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] d;
      logic [4:1]  res;
      bit ok;
      int errs;
      errs = 0;
      for (int k = 0; k < 40; k++) begin
         d = 16'($urandom);
         run16(d, int'($urandom_range(0, 3)), res, ok);
         total++;
         if (!ok || res !== tc5_of(longint'(d))) begin
            bad++;
            errs++;
            if (errs < 5) $display("FAIL sweep16_%h: ok=%b got %b want %b", d, ok, res, tc5_of(longint'(d)));
         end
      end
   endtask

   task automatic test_dw1();
      logic v;
      for (int k = 0; k < 8; k++) begin
         v = (k == 0) ? 1'b1 : 1'($urandom);
         @(negedge clk);
         b1.in_valid = 1'b1;
         b1.in_data  = v;
         @(negedge clk);
         b1.in_valid = 1'b0;
         total++;
         if (b1.out_valid !== 1'b0 || busy1 !== 1'b1) begin
            bad++;
            $display("FAIL dw1_conv%0d: vld=%b busy=%b want 0 1", k, b1.out_valid, busy1);
         end
         @(negedge clk);
         total++;
         if (b1.out_valid !== 1'b1 || b1.out_residue !== tc5_of(longint'(v))) begin
            bad++;
            $display("FAIL dw1_result%0d: vld=%b got %b want %b", k, b1.out_valid, b1.out_residue, tc5_of(longint'(v)));
         end
         b1.out_ready = 1'b1;
         @(negedge clk);
         b1.out_ready = 1'b0;
      end
   endtask

   initial begin
      total          = 0;
      bad            = 0;
      rst_n          = 1'b0;
      b16.in_valid   = 1'b0;
      b16.in_data    = '0;
      b16.out_ready  = 1'b0;
      b1.in_valid    = 1'b0;
      b1.in_data     = '0;
      b1.out_ready   = 1'b0;
      test_reset();
      test_latency();
      test_vectors();
      test_backpressure();
      test_reset_mid();
      test_input_churn();
      test_back_to_back();
      test_dw1();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
